// File: rtl/addsub_pkg.sv
// Shared types and elaboration helpers for the pipelined adder/subtractor.
package addsub_pkg;

  typedef struct packed {
    logic c;
    logic v;
    logic z;
    logic n;
  } addsub_flags_t;

  function automatic int unsigned seg_w(input int unsigned width, input int unsigned stages);
    return width / stages;
  endfunction

  // Legal when the carry chain splits into equal, non-empty segments.
  function automatic bit cfg_ok(input int unsigned width, input int unsigned stages);
    return (stages != 0) && (width >= stages) && ((width % stages) == 0);
  endfunction

endpackage

// File: rtl/addsub_seg.sv
// Combinational SEG_W-bit ripple-carry segment built from full_adder cells.
module addsub_seg #(
  parameter int unsigned SEG_W = 8
) (
  input  logic [SEG_W-1:0] a_i,
  input  logic [SEG_W-1:0] b_i,
  input  logic             ci_i,
  output logic [SEG_W-1:0] s_o,
  output logic             co_o
);

  // Each bit owns its carry net so the chain is never a self-referencing vector.
  for (genvar i = 0; i < SEG_W; i++) begin : g_bit
    logic ci;
    logic co;

    if (i == 0) begin : g_first
      assign ci = ci_i;
    end else begin : g_chain
      assign ci = g_bit[i-1].co;
    end

    full_adder u_fa (
      .a_i  (a_i[i]),
      .b_i  (b_i[i]),
      .ci_i (ci),
      .s_o  (s_o[i]),
      .co_o (co)
    );
  end

  assign co_o = g_bit[SEG_W-1].co;

endmodule

// File: rtl/full_adder.sv
// One-bit full adder cell, the building block of every ripple segment.
module full_adder (
  input  logic a_i,
  input  logic b_i,
  input  logic ci_i,
  output logic s_o,
  output logic co_o
);

  logic p;

  assign p    = a_i ^ b_i;
  assign s_o  = p ^ ci_i;
  assign co_o = (a_i & b_i) | (ci_i & p);

endmodule

// File: rtl/addsub_pipe.sv
// Pipelined adder/subtractor: one ripple segment per register stage, valid/ready
// handshake with per-stage backpressure, flags produced alongside the last segment.
module addsub_pipe
  import addsub_pkg::*;
#(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned STAGES = 4,
  parameter int unsigned TAG_W  = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             sub_i,
  input  logic [TAG_W-1:0] tag_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] s_o,
  output logic             c_o,
  output logic             v_o,
  output logic             z_o,
  output logic             n_o,
  output logic [TAG_W-1:0] tag_o
);

  localparam int unsigned SEG_W = seg_w(WIDTH, STAGES);
  localparam int unsigned LAST  = STAGES - 1;

  if (!cfg_ok(WIDTH, STAGES)) begin : g_bad_cfg
    $error("addsub_pipe: WIDTH must be a non-zero multiple of STAGES");
  end

  logic [STAGES-1:0] vld_q;
  logic [STAGES-1:0] vld_d;
  logic [STAGES-1:0] adv;
  logic [STAGES-1:0] up_adv;

  logic [WIDTH-1:0]  a_q   [STAGES];
  logic [WIDTH-1:0]  bx_q  [STAGES];
  logic [WIDTH-1:0]  s_q   [STAGES];
  logic              c_q   [STAGES];
  logic [TAG_W-1:0]  tag_q [STAGES];
  addsub_flags_t     flags_q;
  addsub_flags_t     flags_d;

  logic [WIDTH-1:0]  a_in   [STAGES];
  logic [WIDTH-1:0]  bx_in  [STAGES];
  logic [WIDTH-1:0]  s_in   [STAGES];
  logic [WIDTH-1:0]  s_nxt  [STAGES];
  logic              c_in   [STAGES];
  logic [TAG_W-1:0]  tag_in [STAGES];

  logic [STAGES-1:0][SEG_W-1:0] seg_s;
  logic [STAGES-1:0]            seg_co;

  // Advance terms resolve from the output back towards the input, so an empty
  // slot anywhere downstream lets the stages behind it keep moving.
  always_comb begin
    logic go;
    adv       = '0;
    up_adv    = '0;
    vld_d     = vld_q;
    go        = vld_q[LAST] & ready_i;
    adv[LAST] = go;
    for (int k = int'(STAGES) - 2; k >= 0; k--) begin
      go     = vld_q[k] & (~vld_q[k+1] | go);
      adv[k] = go;
    end
    ready_o   = ~vld_q[0] | adv[0];
    up_adv[0] = valid_i & ready_o;
    for (int k = 1; k < int'(STAGES); k++) begin
      up_adv[k] = adv[k-1];
    end
    for (int k = 0; k < int'(STAGES); k++) begin
      if (~vld_q[k] | adv[k]) begin
        vld_d[k] = up_adv[k];
      end
    end
  end

  // Stage 0 conditions the operands; later stages consume the upstream register.
  always_comb begin
    a_in[0]   = a_i;
    bx_in[0]  = sub_i ? ~b_i : b_i;
    s_in[0]   = '0;
    c_in[0]   = sub_i;
    tag_in[0] = tag_i;
    for (int k = 1; k < int'(STAGES); k++) begin
      a_in[k]   = a_q[k-1];
      bx_in[k]  = bx_q[k-1];
      s_in[k]   = s_q[k-1];
      c_in[k]   = c_q[k-1];
      tag_in[k] = tag_q[k-1];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_seg
    addsub_seg #(
      .SEG_W (SEG_W)
    ) u_seg (
      .a_i  (a_in[k][k*SEG_W +: SEG_W]),
      .b_i  (bx_in[k][k*SEG_W +: SEG_W]),
      .ci_i (c_in[k]),
      .s_o  (seg_s[k]),
      .co_o (seg_co[k])
    );
  end

  always_comb begin
    for (int k = 0; k < int'(STAGES); k++) begin
      s_nxt[k]                    = s_in[k];
      s_nxt[k][k*SEG_W +: SEG_W] = seg_s[k];
    end
    flags_d.c = seg_co[LAST];
    flags_d.z = (s_nxt[LAST] == '0);
    flags_d.n = s_nxt[LAST][WIDTH-1];
    flags_d.v = (a_in[LAST][WIDTH-1] == bx_in[LAST][WIDTH-1]) &
                (s_nxt[LAST][WIDTH-1] != a_in[LAST][WIDTH-1]);
  end

  // Payload only moves when an operation advances in, so a stalled stage holds.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld_q   <= '0;
      flags_q <= '0;
      for (int k = 0; k < int'(STAGES); k++) begin
        a_q[k]   <= '0;
        bx_q[k]  <= '0;
        s_q[k]   <= '0;
        c_q[k]   <= 1'b0;
        tag_q[k] <= '0;
      end
    end else begin
      vld_q <= vld_d;
      for (int k = 0; k < int'(STAGES); k++) begin
        if (up_adv[k]) begin
          a_q[k]   <= a_in[k];
          bx_q[k]  <= bx_in[k];
          s_q[k]   <= s_nxt[k];
          c_q[k]   <= seg_co[k];
          tag_q[k] <= tag_in[k];
        end
      end
      if (up_adv[LAST]) begin
        flags_q <= flags_d;
      end
    end
  end

  assign valid_o = vld_q[LAST];
  assign s_o     = s_q[LAST];
  assign tag_o   = tag_q[LAST];
  assign c_o     = flags_q.c;
  assign v_o     = flags_q.v;
  assign z_o     = flags_q.z;
  assign n_o     = flags_q.n;

endmodule

// File: tb/tb_addsub_pipe.sv
// Directed bench for addsub_pipe: default 32/4 build plus a WIDTH=8, STAGES=1 build.
module tb_addsub_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_i, ready_o, sub_i, ready_i, valid_o;
  logic        c_o, v_o, z_o, n_o;
  logic [31:0] a_i, b_i, s_o;
  logic [3:0]  tag_i, tag_o;

  logic        sm_valid_i, sm_ready_o, sm_sub_i, sm_ready_i, sm_valid_o;
  logic        sm_c, sm_v, sm_z, sm_n;
  logic [7:0]  sm_a, sm_b, sm_s;
  logic [3:0]  sm_tag_i, sm_tag_o;

  int checks   = 0;
  int failures = 0;
  int seen, first_cyc, last_cyc, acc;

  always #5 clk = ~clk;

  addsub_pipe u_dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .a_i     (a_i),
    .b_i     (b_i),
    .sub_i   (sub_i),
    .tag_i   (tag_i),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .s_o     (s_o),
    .c_o     (c_o),
    .v_o     (v_o),
    .z_o     (z_o),
    .n_o     (n_o),
    .tag_o   (tag_o)
  );

  addsub_pipe #(
    .WIDTH  (8),
    .STAGES (1),
    .TAG_W  (4)
  ) u_small (
    .clk_i   (clk),
    .rst_i   (rst),
    .valid_i (sm_valid_i),
    .ready_o (sm_ready_o),
    .a_i     (sm_a),
    .b_i     (sm_b),
    .sub_i   (sm_sub_i),
    .tag_i   (sm_tag_i),
    .valid_o (sm_valid_o),
    .ready_i (sm_ready_i),
    .s_o     (sm_s),
    .c_o     (sm_c),
    .v_o     (sm_v),
    .z_o     (sm_z),
    .n_o     (sm_n),
    .tag_o   (sm_tag_o)
  );

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", name, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic single(input string nm, input logic [31:0] a, input logic [31:0] b,
                        input logic sub, input logic [3:0] tag, input logic [31:0] es,
                        input logic ec, input logic ev, input logic ez, input logic en);
    ready_i = 1'b1;
    valid_i = 1'b1;
    a_i     = a;
    b_i     = b;
    sub_i   = sub;
    tag_i   = tag;
    tick();
    valid_i = 1'b0;
    tick();
    tick();
    check({nm, "_early"}, 64'(valid_o), 64'd0);
    tick();
    check({nm, "_valid"}, 64'(valid_o), 64'd1);
    check({nm, "_s"},     64'(s_o),     64'(es));
    check({nm, "_c"},     64'(c_o),     64'(ec));
    check({nm, "_v"},     64'(v_o),     64'(ev));
    check({nm, "_z"},     64'(z_o),     64'(ez));
    check({nm, "_n"},     64'(n_o),     64'(en));
    check({nm, "_tag"},   64'(tag_o),   64'(tag));
    tick();
  endtask

  initial begin
    rst        = 1'b1;
    valid_i    = 1'b0;
    ready_i    = 1'b1;
    a_i        = '0;
    b_i        = '0;
    sub_i      = 1'b0;
    tag_i      = '0;
    sm_valid_i = 1'b0;
    sm_ready_i = 1'b1;
    sm_a       = '0;
    sm_b       = '0;
    sm_sub_i   = 1'b0;
    sm_tag_i   = '0;
    tick();
    tick();
    rst = 1'b0;

    check("rst_valid", 64'(valid_o), 64'd0);
    check("rst_s",     64'(s_o),     64'd0);
    check("rst_tag",   64'(tag_o),   64'd0);
    check("rst_flags", 64'({c_o, v_o, z_o, n_o}), 64'd0);
    check("rst_ready", 64'(ready_o), 64'd1);
    check("rst_small_valid", 64'(sm_valid_o), 64'd0);

    single("add",   32'h0000_0005, 32'h0000_0003, 1'b0, 4'h3, 32'h0000_0008, 0, 0, 0, 0);
    single("subeq", 32'h0000_0007, 32'h0000_0007, 1'b1, 4'h5, 32'h0000_0000, 1, 0, 1, 0);
    single("subov", 32'h8000_0000, 32'h0000_0001, 1'b1, 4'h6, 32'h7FFF_FFFF, 1, 1, 0, 0);
    single("carry", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 4'h7, 32'h0000_0000, 1, 0, 1, 0);
    single("addov", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 4'h9, 32'h8000_0000, 0, 1, 0, 1);

    // Streaming: 8 back-to-back operations with the sink always ready.
    ready_i   = 1'b1;
    seen      = 0;
    first_cyc = -1;
    last_cyc  = -1;
    for (int cyc = 0; cyc < 14; cyc++) begin
      if (cyc < 8) begin
        valid_i = 1'b1;
        a_i     = 32'(cyc);
        b_i     = 32'h10;
        sub_i   = 1'b0;
        tag_i   = 4'(cyc);
      end else begin
        valid_i = 1'b0;
      end
      tick();
      if (valid_o) begin
        check("stream_tag", 64'(tag_o), 64'(seen));
        check("stream_s",   64'(s_o),   64'(seen + 16));
        if (first_cyc < 0) first_cyc = cyc;
        last_cyc = cyc;
        seen++;
      end
    end
    check("stream_count",   64'(seen),                 64'd8);
    check("stream_latency", 64'(first_cyc),            64'd3);
    check("stream_consec",  64'(last_cyc - first_cyc), 64'd7);

    // Backpressure: sink stalled, source keeps offering.
    ready_i = 1'b0;
    acc     = 0;
    for (int cyc = 0; cyc < 6; cyc++) begin
      valid_i = 1'b1;
      a_i     = 32'(8 + cyc);
      b_i     = 32'h10;
      sub_i   = 1'b0;
      tag_i   = 4'(8 + cyc);
      #1;
      if (ready_o) acc++;
      tick();
      if (cyc >= 3) begin
        check("bp_hold_valid", 64'(valid_o), 64'd1);
        check("bp_hold_s",     64'(s_o),     64'h18);
        check("bp_hold_tag",   64'(tag_o),   64'd8);
      end
    end
    check("bp_accepted", 64'(acc),     64'd4);
    check("bp_ready",    64'(ready_o), 64'd0);
    valid_i = 1'b0;
    ready_i = 1'b1;
    #1;
    seen = 0;
    for (int cyc = 0; cyc < 10; cyc++) begin
      if (valid_o) begin
        check("bp_drain_tag", 64'(tag_o), 64'(8 + seen));
        check("bp_drain_s",   64'(s_o),   64'(24 + seen));
        seen++;
      end
      tick();
    end
    check("bp_drain_count", 64'(seen), 64'd4);

    // Bubble collapse: head stalls at the output while the rest fills behind it.
    ready_i = 1'b1;
    valid_i = 1'b1;
    a_i     = 32'd1;
    b_i     = 32'h10;
    sub_i   = 1'b0;
    tag_i   = 4'd1;
    #1;
    check("bub_ready0", 64'(ready_o), 64'd1);
    tick();
    ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      a_i   = 32'(2 + i);
      tag_i = 4'(2 + i);
      #1;
      check("bub_ready", 64'(ready_o), 64'd1);
      tick();
    end
    check("bub_full",     64'(ready_o), 64'd0);
    check("bub_head_vld", 64'(valid_o), 64'd1);
    check("bub_head_tag", 64'(tag_o),   64'd1);
    valid_i = 1'b0;
    ready_i = 1'b1;
    #1;
    seen = 0;
    for (int cyc = 0; cyc < 8; cyc++) begin
      if (valid_o) begin
        check("bub_drain_tag", 64'(tag_o), 64'(1 + seen));
        seen++;
      end
      tick();
    end
    check("bub_drain_count", 64'(seen), 64'd4);

    // Reset with three operations in flight plus one offered during reset.
    ready_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      valid_i = 1'b1;
      a_i     = 32'(100 + i);
      b_i     = 32'h1;
      tag_i   = 4'(10 + i);
      tick();
    end
    tag_i = 4'd13;
    rst   = 1'b1;
    tick();
    rst     = 1'b0;
    valid_i = 1'b0;
    check("mid_rst_valid", 64'(valid_o), 64'd0);
    check("mid_rst_s",     64'(s_o),     64'd0);
    check("mid_rst_tag",   64'(tag_o),   64'd0);
    check("mid_rst_ready", 64'(ready_o), 64'd1);
    seen = 0;
    for (int cyc = 0; cyc < 8; cyc++) begin
      if (valid_o) seen++;
      tick();
    end
    check("mid_rst_ghosts", 64'(seen), 64'd0);

    // Single-stage 8-bit build.
    sm_valid_i = 1'b1;
    sm_a       = 8'h7F;
    sm_b       = 8'h01;
    sm_sub_i   = 1'b0;
    sm_tag_i   = 4'h6;
    #1;
    check("sm_pre_valid", 64'(sm_valid_o), 64'd0);
    tick();
    sm_valid_i = 1'b0;
    check("sm_valid", 64'(sm_valid_o), 64'd1);
    check("sm_s",     64'(sm_s),       64'h80);
    check("sm_flags", 64'({sm_c, sm_v, sm_z, sm_n}), 64'b0101);
    check("sm_tag",   64'(sm_tag_o),   64'h6);
    sm_valid_i = 1'b1;
    sm_a       = 8'h00;
    sm_b       = 8'h01;
    sm_sub_i   = 1'b1;
    sm_tag_i   = 4'h9;
    tick();
    sm_valid_i = 1'b0;
    check("sm_sub_s",     64'(sm_s), 64'hFF);
    check("sm_sub_flags", 64'({sm_c, sm_v, sm_z, sm_n}), 64'b0001);
    check("sm_sub_tag",   64'(sm_tag_o), 64'h9);
    tick();
    check("sm_drained", 64'(sm_valid_o), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
